// File: rtl/bus_codes_pkg.sv
// Shared bus code space for the transfer decoder and the bus-mux encoder.
// Both sides import this package so their code values cannot drift apart.
package bus_codes_pkg;

  localparam int CODE_W  = 5;
  localparam int EN_W    = 32;
  localparam int NUM_SRC = 24;

  localparam logic [CODE_W-1:0] CODE_R0     = 5'd0;
  localparam logic [CODE_W-1:0] CODE_R1     = 5'd1;
  localparam logic [CODE_W-1:0] CODE_R2     = 5'd2;
  localparam logic [CODE_W-1:0] CODE_R3     = 5'd3;
  localparam logic [CODE_W-1:0] CODE_R4     = 5'd4;
  localparam logic [CODE_W-1:0] CODE_R5     = 5'd5;
  localparam logic [CODE_W-1:0] CODE_R6     = 5'd6;
  localparam logic [CODE_W-1:0] CODE_R7     = 5'd7;
  localparam logic [CODE_W-1:0] CODE_R8     = 5'd8;
  localparam logic [CODE_W-1:0] CODE_R9     = 5'd9;
  localparam logic [CODE_W-1:0] CODE_R10    = 5'd10;
  localparam logic [CODE_W-1:0] CODE_R11    = 5'd11;
  localparam logic [CODE_W-1:0] CODE_R12    = 5'd12;
  localparam logic [CODE_W-1:0] CODE_R13    = 5'd13;
  localparam logic [CODE_W-1:0] CODE_R14    = 5'd14;
  localparam logic [CODE_W-1:0] CODE_R15    = 5'd15;
  localparam logic [CODE_W-1:0] CODE_HI     = 5'd16;
  localparam logic [CODE_W-1:0] CODE_LO     = 5'd17;
  localparam logic [CODE_W-1:0] CODE_ZHIGH  = 5'd18;
  localparam logic [CODE_W-1:0] CODE_ZLOW   = 5'd19;
  localparam logic [CODE_W-1:0] CODE_PC     = 5'd20;
  localparam logic [CODE_W-1:0] CODE_MDR    = 5'd21;
  localparam logic [CODE_W-1:0] CODE_INPORT = 5'd22;
  localparam logic [CODE_W-1:0] CODE_C      = 5'd23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2
  } xfer_state_t;

endpackage

// File: rtl/onehot_decoder.sv
// Bus code to one-hot enable decoder. Codes outside the populated range
// decode to all-zero so unused enable bits can never assert.
module onehot_decoder
  import bus_codes_pkg::*;
#(
  parameter int CODE_W_P  = CODE_W,
  parameter int EN_W_P    = EN_W,
  parameter int NUM_SRC_P = NUM_SRC
) (
  input  logic [CODE_W_P-1:0] code,
  output logic [EN_W_P-1:0]   onehot,
  output logic                in_range
);

  always_comb begin
    in_range = (int'(code) < NUM_SRC_P);
    onehot   = '0;
    if (in_range) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/bus_xfer_decoder.sv
// Two-phase shared-bus transfer sequencer: accepts (src, dst) codes and drives
// the source out-enable, then adds the destination in-enable for one cycle.
//
// state   | meaning
// IDLE    | ready for a request; enables off
// DRIVE   | source out-enable on, destination off
// CAPTURE | source held, destination in-enable on; done follows
module bus_xfer_decoder
  import bus_codes_pkg::*;
#(
  parameter int NUM_SRC_P = NUM_SRC,
  parameter int CODE_W_P  = CODE_W,
  parameter int EN_W_P    = EN_W
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CODE_W_P-1:0] req_src,
  input  logic [CODE_W_P-1:0] req_dst,
  output logic [EN_W_P-1:0]   src_out,
  output logic [EN_W_P-1:0]   dst_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         xfer_count
);

  xfer_state_t       state_q, state_d;
  logic [EN_W_P-1:0] src_dec, dst_dec;
  logic              src_ok, dst_ok;
  logic [EN_W_P-1:0] dst_vec_q, dst_vec_d;
  logic [EN_W_P-1:0] src_out_d, dst_in_d;
  logic              busy_d, ready_d, done_d, err_d;
  logic [15:0]       count_d;

  onehot_decoder #(.CODE_W_P(CODE_W_P), .EN_W_P(EN_W_P), .NUM_SRC_P(NUM_SRC_P)) u_src_dec (
    .code     (req_src),
    .onehot   (src_dec),
    .in_range (src_ok)
  );

  onehot_decoder #(.CODE_W_P(CODE_W_P), .EN_W_P(EN_W_P), .NUM_SRC_P(NUM_SRC_P)) u_dst_dec (
    .code     (req_dst),
    .onehot   (dst_dec),
    .in_range (dst_ok)
  );

  always_comb begin
    state_d   = state_q;
    dst_vec_d = dst_vec_q;
    src_out_d = src_out;
    dst_in_d  = dst_in;
    busy_d    = busy;
    ready_d   = req_ready;
    done_d    = 1'b0;
    err_d     = 1'b0;
    count_d   = xfer_count;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (src_ok && dst_ok) begin
            state_d   = DRIVE;
            src_out_d = src_dec;
            dst_in_d  = '0;
            dst_vec_d = dst_dec;
            busy_d    = 1'b1;
            ready_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        state_d  = CAPTURE;
        dst_in_d = dst_vec_q;
      end
      CAPTURE: begin
        state_d   = IDLE;
        src_out_d = '0;
        dst_in_d  = '0;
        busy_d    = 1'b0;
        ready_d   = 1'b1;
        done_d    = 1'b1;
        count_d   = xfer_count + 16'd1;
      end
      default: begin
        state_d   = IDLE;
        src_out_d = '0;
        dst_in_d  = '0;
        busy_d    = 1'b0;
        ready_d   = 1'b1;
      end
    endcase
  end

  // Every output is a flop: the enables drive large bus-mux fan-out directly.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      dst_vec_q  <= '0;
      src_out    <= '0;
      dst_in     <= '0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      xfer_count <= 16'd0;
    end else begin
      state_q    <= state_d;
      dst_vec_q  <= dst_vec_d;
      src_out    <= src_out_d;
      dst_in     <= dst_in_d;
      busy       <= busy_d;
      req_ready  <= ready_d;
      done       <= done_d;
      err        <= err_d;
      xfer_count <= count_d;
    end
  end

endmodule

// File: tb/tb_bus_xfer_decoder.sv
// Directed bench for bus_xfer_decoder: expected per-cycle outputs are queued
// as stimulus is applied and compared one entry per clock.
module tb_bus_xfer_decoder;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_src, req_dst;
  logic [31:0] src_out, dst_in;
  logic        busy, done, err;
  logic [15:0] xfer_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic        busy;
    logic        ready;
    logic        done;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt = 16'd0;

  bus_xfer_decoder dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .src_out    (src_out),
    .dst_in     (dst_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] oh(input int code);
    logic [31:0] v;
    v = 32'd0;
    if (code < 24) v[code] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic b,
                      input logic r, input logic dn, input logic e);
    exp_t x;
    x.src = s; x.dst = d; x.busy = b; x.ready = r; x.done = dn; x.err = e; x.cnt = exp_cnt;
    sb.push_back(x);
  endtask

  task automatic push_idle(input logic dn, input logic e);
    push(32'd0, 32'd0, 1'b0, 1'b1, dn, e);
  endtask

  task automatic push_drive(input int s);
    push(oh(s), 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_capture(input int s, input int d);
    push(oh(s), oh(d), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_done();
    exp_cnt = exp_cnt + 16'd1;
    push_idle(1'b1, 1'b0);
  endtask

  task automatic cycle(input string tag);
    exp_t x;
    @(posedge clk);
    @(negedge clk);
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_queue: observed empty scoreboard expected an entry", tag);
      return;
    end
    x = sb.pop_front();
    chk({tag, "_src_out"},   src_out,           x.src);
    chk({tag, "_dst_in"},    dst_in,            x.dst);
    chk({tag, "_busy"},      {31'd0, busy},     {31'd0, x.busy});
    chk({tag, "_ready"},     {31'd0, req_ready},{31'd0, x.ready});
    chk({tag, "_done"},      {31'd0, done},     {31'd0, x.done});
    chk({tag, "_err"},       {31'd0, err},      {31'd0, x.err});
    chk({tag, "_count"},     {16'd0, xfer_count}, {16'd0, x.cnt});
  endtask

  task automatic request(input int s, input int d);
    req_valid = 1'b1;
    req_src   = 5'(s);
    req_dst   = 5'(d);
  endtask

  initial begin
    clr_n     = 1'b0;
    req_valid = 1'b0;
    req_src   = 5'd0;
    req_dst   = 5'd0;
    @(negedge clk);

    // reset held two cycles, then idle
    push_idle(1'b0, 1'b0); cycle("rst0");
    push_idle(1'b0, 1'b0); cycle("rst1");
    clr_n = 1'b1;
    push_idle(1'b0, 1'b0); cycle("idle");

    // reset during CAPTURE of 5->6 aborts: no done, no increment
    request(5, 6);
    push_drive(5);        cycle("abort_drive");
    req_valid = 1'b0;
    push_capture(5, 6);   cycle("abort_capture");
    clr_n = 1'b0;
    push_idle(1'b0, 1'b0); cycle("abort_rst");
    clr_n = 1'b1;
    push_idle(1'b0, 1'b0); cycle("abort_after");

    // PC -> MDR; inputs change after accept and must be ignored
    request(20, 21);
    push_drive(20);       cycle("pc_drive");
    req_valid = 1'b0; req_src = 5'd7; req_dst = 5'd9;
    push_capture(20, 21); cycle("pc_capture");
    push_done();          cycle("pc_done");
    push_idle(1'b0, 1'b0); cycle("pc_idle");

    // invalid destination
    request(3, 27);
    push_idle(1'b0, 1'b1); cycle("inv_err");
    req_valid = 1'b0;
    push_idle(1'b0, 1'b0); cycle("inv_after");

    // first invalid code is 24; back-to-back invalid gives one err each
    request(24, 0);
    push_idle(1'b0, 1'b1); cycle("inv24_a");
    request(0, 31);
    push_idle(1'b0, 1'b1); cycle("inv24_b");
    req_valid = 1'b0;
    push_idle(1'b0, 1'b0); cycle("inv24_after");

    // highest valid code, src == dst
    request(23, 23);
    push_drive(23);       cycle("same_drive");
    req_valid = 1'b0;
    push_capture(23, 23); cycle("same_capture");
    push_done();          cycle("same_done");

    // back-to-back with valid held high: 0->1 then 23->16
    request(0, 1);
    push_drive(0);        cycle("b2b_drive0");
    push_capture(0, 1);   cycle("b2b_capture0");
    request(23, 16);
    push_done();          cycle("b2b_done0");
    push_drive(23);       cycle("b2b_drive1");
    req_valid = 1'b0;
    push_capture(23, 16); cycle("b2b_capture1");
    push_done();          cycle("b2b_done1");

    // count wrap: preset to 0xFFFF then one transfer
    force dut.xfer_count = 16'hFFFF;
    #1;
    release dut.xfer_count;
    exp_cnt = 16'hFFFF;
    push_idle(1'b0, 1'b0); cycle("wrap_pre");
    request(22, 17);
    push_drive(22);       cycle("wrap_drive");
    req_valid = 1'b0;
    push_capture(22, 17); cycle("wrap_capture");
    push_done();          cycle("wrap_done");
    push_idle(1'b0, 1'b0); cycle("wrap_idle");

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL leftover: observed %0d queued entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
